// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for the picorv32 native memory bus.
// Master 0 is the CPU and master 1 is the loader/DMA engine. Both masters
// share one downstream decoder port. Arbitration is round-robin by default,
// or master 0 wins every tie when FIXED_PRIO=1. The arbiter forces one idle
// cycle on s_valid between transactions, because slaves start an access on
// the rising edge of valid.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the slave-response
// watchdog (TIMEOUT cycles; completes the access with ERR_RDATA and pulses
// err_timeout).
module mem_bus_arbiter #(
   parameter int          FIXED_PRIO = 0,
   parameter int          TIMEOUT    = 256,
   parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_q, last_d;   // index of the master served most recently
   logic        sel_valid;
   logic        req_live;
   logic        to_hit;
   logic        done;
   logic [31:0] rd_mux;

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT must be within 2..65535");
   end

   // The owner's request is still being held; dropping it aborts the access.
   assign sel_valid = (grant_q[0] & m0_valid) | (grant_q[1] & m1_valid);
   assign req_live  = (state_q == BUSY) & sel_valid;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   // Watchdog counter: zeroed while idle, counts BUSY cycles without s_ready.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE)
         cnt_d = 16'd0;
      else if (state_q == BUSY && !s_ready)
         cnt_d = cnt_q + 16'd1;
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= 16'd0;
      else
         cnt_q <= cnt_d;
   end

   // A real s_ready in the expiry cycle wins over the watchdog.
   assign to_hit      = req_live & ~s_ready & (cnt_q == TO_LAST);
   assign err_timeout = to_hit;
`else
   assign to_hit      = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign done  = req_live & (s_ready | to_hit);
   assign grant = grant_q;

   // Request path: owner's fields go downstream, zeros while nobody owns the bus.
   always_comb begin
      s_addr  = 32'd0;
      s_wdata = 32'd0;
      s_wstrb = 4'd0;
      if (grant_q[0]) begin
         s_addr  = m0_addr;
         s_wdata = m0_wdata;
         s_wstrb = m0_wstrb;
      end else if (grant_q[1]) begin
         s_addr  = m1_addr;
         s_wdata = m1_wdata;
         s_wstrb = m1_wstrb;
      end
   end

   // Response path: only the owner sees ready/rdata; a timed-out read gets ERR_RDATA.
   always_comb begin
      rd_mux = s_rdata;
      if (to_hit)
         rd_mux = (s_wstrb == 4'd0) ? ERR_RDATA : 32'd0;
      s_valid  = req_live;
      m0_ready = grant_q[0] & done;
      m1_ready = grant_q[1] & done;
      m0_rdata = grant_q[0] ? rd_mux : 32'd0;
      m1_rdata = grant_q[1] ? rd_mux : 32'd0;
   end

   // Next-state logic: arbitrate in IDLE, hold the owner in BUSY, one GAP cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               if (m0_valid && m1_valid)
                  last_d = (FIXED_PRIO == 0) ? ~last_q : 1'b0;
               else
                  last_d = m1_valid;
               grant_d = last_d ? 2'b10 : 2'b01;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!sel_valid || s_ready || to_hit) begin
               grant_d = 2'b00;
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; the pointer resets to master 1 so master 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin instance (TIMEOUT=8) and
// a fixed-priority instance, driven by one linear stimulus sequence.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        err_timeout;

   logic        b_m0_valid, b_m0_ready, b_m1_valid, b_m1_ready;
   logic [31:0] b_m0_rdata, b_m1_rdata;
   logic        b_s_valid, b_s_ready;
   logic [31:0] b_s_addr, b_s_wdata;
   logic [3:0]  b_s_wstrb;
   logic [1:0]  b_grant;
   logic        b_err_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .ERR_RDATA(32'hDEAD_BEEF)) u_rr (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .grant(grant), .err_timeout(err_timeout)
   );

   mem_bus_arbiter #(.FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset),
      .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_addr(32'h0000_1000),
      .m0_wdata(32'd0), .m0_wstrb(4'd0), .m0_rdata(b_m0_rdata),
      .m1_valid(b_m1_valid), .m1_ready(b_m1_ready), .m1_addr(32'h0000_2000),
      .m1_wdata(32'd0), .m1_wstrb(4'd0), .m1_rdata(b_m1_rdata),
      .s_valid(b_s_valid), .s_ready(b_s_ready), .s_addr(b_s_addr),
      .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_rdata(32'h0000_0000),
      .grant(b_grant), .err_timeout(b_err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=stuck expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 1'b1;
      m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      s_ready = 0; s_rdata = 0;
      b_m0_valid = 0; b_m1_valid = 0; b_s_ready = 0;

      // reset values
      #12;
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_valid", s_valid, 1'b0);
      chk("rst_m0_ready", m0_ready, 1'b0);
      chk("rst_m1_ready", m1_ready, 1'b0);
      chk("rst_err", err_timeout, 1'b0);
      chk("rst_b_grant", b_grant, 2'b00);
      tick();
      reset = 1'b0;

      // round-robin tie: grants 01,10,01,10; m1 write data only under grant 10
      m0_valid = 1; m0_addr = 32'h0000_0200; m0_wdata = 32'h5A5A_0000; m0_wstrb = 4'h0;
      m1_valid = 1; m1_addr = 32'h0000_0300; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
      s_ready = 1; s_rdata = 32'h0BAD_F00D;
      #1;
      chk("rr_idle_s_valid", s_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_grant", grant, (i % 2 == 1) ? 2'b10 : 2'b01);
         chk("rr_s_valid", s_valid, 1'b1);
         chk("rr_s_wdata", s_wdata, (i % 2 == 1) ? 32'hA5A5_A5A5 : 32'h5A5A_0000);
         chk("rr_s_wstrb", s_wstrb, (i % 2 == 1) ? 4'hF : 4'h0);
         chk("rr_m0_ready", m0_ready, (i % 2 == 0));
         chk("rr_m1_ready", m1_ready, (i % 2 == 1));
         tick();
         chk("rr_gap_s_valid", s_valid, 1'b0);
         chk("rr_gap_grant", grant, 2'b00);
         chk("rr_gap_s_wdata", s_wdata, 32'd0);
         tick();
         chk("rr_idle2_s_valid", s_valid, 1'b0);
      end

      // reset while m1 owns the bus, then a tie goes to m0
      m0_valid = 0; s_ready = 0;
      tick();
      chk("rs_busy_grant", grant, 2'b10);
      s_ready = 1;
      #1;
      chk("rs_m1_ready_pre", m1_ready, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("rs_async_s_valid", s_valid, 1'b0);
      chk("rs_async_grant", grant, 2'b00);
      chk("rs_async_m1_ready", m1_ready, 1'b0);
      tick();
      reset = 1'b0;
      m0_valid = 1; s_ready = 0;
      tick();
      chk("rs_tie_grant", grant, 2'b01);
      s_ready = 1;
      tick();
      m0_valid = 0; m1_valid = 0; s_ready = 0;
      tick();

      // m0 abandons its request in BUSY before s_ready
      m0_valid = 1; m0_addr = 32'h0000_0400; m0_wstrb = 4'h0;
      tick();
      chk("pv_busy_s_valid", s_valid, 1'b1);
      chk("pv_busy_grant", grant, 2'b01);
      m0_valid = 0;
      #1;
      chk("pv_drop_s_valid", s_valid, 1'b0);
      chk("pv_drop_m0_ready", m0_ready, 1'b0);
      tick();
      chk("pv_gap_grant", grant, 2'b00);
      tick();
      chk("pv_idle_grant", grant, 2'b00);
      chk("pv_idle_s_valid", s_valid, 1'b0);

      // single read: slave answers on the second BUSY cycle
      m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
      s_rdata = 32'h0;
      tick();
      chk("rd_s_valid", s_valid, 1'b1);
      chk("rd_s_addr", s_addr, 32'h0000_0100);
      chk("rd_m0_ready_wait", m0_ready, 1'b0);
      tick();
      chk("rd_m0_ready_wait2", m0_ready, 1'b0);
      s_ready = 1; s_rdata = 32'h1234_5678;
      #1;
      chk("rd_m0_ready", m0_ready, 1'b1);
      chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
      chk("rd_m1_rdata", m1_rdata, 32'd0);
      chk("rd_m1_ready", m1_ready, 1'b0);
      tick();
      m0_valid = 0; s_ready = 0;
      #1;
      chk("rd_gap_s_valid", s_valid, 1'b0);
      chk("rd_gap_m0_rdata", m0_rdata, 32'd0);
      tick();
      chk("rd_idle_s_valid", s_valid, 1'b0);

      // fixed priority: m1 waits while m0 keeps requesting
      b_m0_valid = 1; b_m1_valid = 1; b_s_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fp_grant_m0", b_grant, 2'b01);
         chk("fp_m1_ready", b_m1_ready, 1'b0);
         tick();
         tick();
      end
      b_m0_valid = 0;
      tick();
      chk("fp_grant_m1", b_grant, 2'b10);
      chk("fp_m1_ready_done", b_m1_ready, 1'b1);
      b_m1_valid = 0; b_s_ready = 0;
      tick();
      tick();

      // slave never answers an m0 read
      m0_valid = 1; m0_addr = 32'h0000_0500; m0_wstrb = 4'h0;
      s_ready = 0; s_rdata = 32'h0;
      tick();
      for (int c = 1; c < 8; c++) begin
         chk("to_wait_err", err_timeout, 1'b0);
         chk("to_wait_ready", m0_ready, 1'b0);
         tick();
      end
`ifdef MEM_ARB_TIMEOUT_EN
      chk("to_m0_ready", m0_ready, 1'b1);
      chk("to_err", err_timeout, 1'b1);
      chk("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      tick();
      chk("to_gap_err", err_timeout, 1'b0);
      chk("to_gap_grant", grant, 2'b00);
      m0_valid = 0;
      tick();
`else
      chk("nt_s_valid8", s_valid, 1'b1);
      chk("nt_err8", err_timeout, 1'b0);
      repeat (100) tick();
      chk("nt_s_valid108", s_valid, 1'b1);
      chk("nt_grant108", grant, 2'b01);
      chk("nt_m0_ready108", m0_ready, 1'b0);
      m0_valid = 0;
      #1;
      chk("nt_release_s_valid", s_valid, 1'b0);
      tick();
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master round-robin arbiter on the picorv32 native memory bus: valid/ready, addr, wdata, wstrb, rdata.
- Lets a second requester (boot loader or DMA engine, master 1) share the RAM/IO/UART address space with the CPU (master 0).
- Sits between the masters and the existing address decoder.
- Forces one idle cycle on s_valid between transactions, because downstream slaves start an access on a rising edge of valid.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins simultaneous requests.
- TIMEOUT, 256, slave-response watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN; legal 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- m0_valid  in  1  master 0 (CPU) request.
- m0_ready  out  1  master 0 completion.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 = read.
- m0_rdata  out  32  master 0 read data.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0_*, for master 1 (loader/DMA).
- s_valid  out  1  request to decoder/slaves.
- s_ready  in  1  slave completion.
- s_addr  out  32  muxed address.
- s_wdata  out  32  muxed write data.
- s_wstrb  out  4  muxed strobes.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot owner; 2'b00 when idle.
- err_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; grant = 0; s_valid = 0; m0_ready = m1_ready = 0; err_timeout = 0.
  - last-served pointer = 1, so master 0 wins the first tie.
- States: IDLE, BUSY, GAP.
- IDLE:
  - Sample m0_valid/m1_valid.
  - Only one requesting: grant it.
  - Both requesting: FIXED_PRIO=1 grants m0; otherwise grant the master that is not the last-served one.
  - On grant: register grant one-hot, update the last-served pointer, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - s_valid = 1.
  - s_addr/s_wdata/s_wstrb are a combinational mux of the granted master's inputs.
  - Granted mN_ready = s_ready (combinational).
  - Granted mN_rdata = s_rdata.
  - Non-granted master: ready = 0, rdata = 0.
  - s_ready = 1: go to GAP.
  - Granted master drops valid before s_ready (protocol violation): s_valid drops the same cycle, no ready is issued, go to GAP.
- GAP:
  - Exactly one cycle; s_valid = 0, grant = 0.
  - Then IDLE.
- Muxed outputs when grant = 0: s_addr, s_wdata and s_wstrb are 0.
- Latency:
  - Request seen at cycle N: s_valid at N+1.
  - Master ready in the same cycle as s_ready.
  - Minimum back-to-back spacing between grants: 3 cycles (IDLE, BUSY, GAP).
- Ownership: no preemption. A request arriving during BUSY/GAP waits; its valid stays high per protocol.
- Starvation bound (round-robin): a continuously requesting master waits at most one transaction of the other master.
- Reset asserted mid-BUSY: all outputs return to reset values immediately (async); the in-flight access is abandoned.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle with s_ready = 0.
  - When it reaches TIMEOUT-1 with s_ready still 0, that cycle:
    - granted mN_ready = 1;
    - mN_rdata = ERR_RDATA on reads;
    - writes are dropped;
    - err_timeout = 1 for one cycle;
    - next state GAP.
  - s_ready in the same cycle as expiry takes precedence: normal completion, no err_timeout.
- Not defined:
  - No counter logic; BUSY waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
- Single read: m0 read addr 0x0000_0100, slave returns 0x1234_5678 after 2 cycles -> s_valid from N+1, m0_ready pulses with s_ready, m0_rdata = 0x1234_5678, s_valid low for one GAP cycle.
- Simultaneous requests, FIXED_PRIO=0, both held for 4 transactions -> grant sequence 01,10,01,10; m1 write wstrb 4'hF data 0xA5A5_A5A5 reaches s_wdata only while grant = 10.
- FIXED_PRIO=1, m0 requests continuously while m1 waits -> m1 never granted until m0_valid drops; then granted within 3 cycles.
- Reset pulse asserted in BUSY (m1 owns bus) -> s_valid, grant, m1_ready go 0 without waiting for clk; after release, a tie grants m0 first.
- m0 drops valid while in BUSY before s_ready -> s_valid 0 same cycle, no m0_ready pulse, GAP then IDLE.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=8, slave never readies on m0 read -> m0_ready and err_timeout pulse on 8th BUSY cycle, m0_rdata = 0xDEAD_BEEF; without macro, bus stays BUSY for 100+ cycles.
